// File: rtl/register_file.sv
// Two-read/one-write register file with per-entry pending bits and a reserve port; optional REGFILE_BYPASS_EN forwards same-edge writes to reads.
// Latency: read data and reserve result appear one cycle after the request edge.
// Backpressure: none; every write, reserve and read completes in a single cycle.
module register_file #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wen,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_ren1,
    input  logic [AW-1:0]    i_raddr1,
    output logic [WIDTH-1:0] o_bl1,
    output logic             o_vld1,
    output logic             o_pend1,
    input  logic             i_ren2,
    input  logic [AW-1:0]    i_raddr2,
    output logic [WIDTH-1:0] o_bl2,
    output logic             o_vld2,
    output logic             o_pend2,
    input  logic             i_rsv,
    input  logic [AW-1:0]    i_rsv_addr,
    output logic             o_rsv_ok
);

    // One extra bit so DEPTH itself is representable when DEPTH is a power of two.
    localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_pend;
    logic             r_rsv_ok;

    logic [DEPTH-1:0] w_pend_nxt;
    logic             w_wr_hit;
    logic             w_rsv_hit;
    logic             w_rsv_ok_nxt;
    logic [1:0]       w_ren;
    logic [AW-1:0]    w_raddr [2];

    assign w_wr_hit  = i_wen && ({1'b0, i_waddr} < LP_DEPTH);
    assign w_rsv_hit = i_rsv && ({1'b0, i_rsv_addr} < LP_DEPTH);

    assign w_ren      = {i_ren2, i_ren1};
    assign w_raddr[0] = i_raddr1;
    assign w_raddr[1] = i_raddr2;

    // The write clears its pending bit before the reserve looks at it, so a
    // same-address write+reserve always succeeds and leaves the entry pending.
    always_comb begin
        w_pend_nxt   = r_pend;
        w_rsv_ok_nxt = 1'b0;
        if (w_wr_hit) begin
            w_pend_nxt[i_waddr] = 1'b0;
        end
        if (w_rsv_hit && !w_pend_nxt[i_rsv_addr]) begin
            w_pend_nxt[i_rsv_addr] = 1'b1;
            w_rsv_ok_nxt           = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_pend   <= '0;
            r_rsv_ok <= 1'b0;
        end else begin
            if (w_wr_hit) begin
                r_mem[i_waddr] <= i_d;
            end
            r_pend   <= w_pend_nxt;
            r_rsv_ok <= w_rsv_ok_nxt;
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic             w_in;
        logic             w_fwd;
        logic [WIDTH-1:0] w_dat;
        logic             w_pnd;
        logic [WIDTH-1:0] r_bl;
        logic             r_vld;
        logic             r_pnd;

        assign w_in = ({1'b0, w_raddr[p]} < LP_DEPTH);
`ifdef REGFILE_BYPASS_EN
        assign w_fwd = w_wr_hit && (i_waddr == w_raddr[p]);
`else
        assign w_fwd = 1'b0;
`endif
        assign w_dat = !w_in ? '0 : (w_fwd ? i_d : r_mem[w_raddr[p]]);
        assign w_pnd = w_in && !w_fwd && r_pend[w_raddr[p]];

        always_ff @(posedge i_clk) begin
            if (!i_rst) begin
                r_bl  <= '0;
                r_vld <= 1'b0;
                r_pnd <= 1'b0;
            end else begin
                r_bl  <= w_ren[p] ? w_dat : '0;
                r_vld <= w_ren[p];
                r_pnd <= w_ren[p] && w_pnd;
            end
        end
    end

    assign o_bl1    = g_rd[0].r_bl;
    assign o_vld1   = g_rd[0].r_vld;
    assign o_pend1  = g_rd[0].r_pnd;
    assign o_bl2    = g_rd[1].r_bl;
    assign o_vld2   = g_rd[1].r_vld;
    assign o_pend2  = g_rd[1].r_pnd;
    assign o_rsv_ok = r_rsv_ok;

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter WIDTH, default 16: bits per register.
REQ-002 Parameter DEPTH, default 8: number of registers, legal range 2..256.
REQ-003 Parameter AW, default $clog2(DEPTH): address width.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, synchronous and active-low: state clears on a rising clk edge while rst=0.
REQ-006 wen  in  1  write enable.
REQ-007 waddr  in  AW  write address.
REQ-008 d  in  WIDTH  write data.
REQ-009 ren1  in  1  read enable, port 1.
REQ-010 raddr1  in  AW  read address, port 1.
REQ-011 bl1  out  WIDTH  read data, port 1, registered.
REQ-012 vld1  out  1  bl1 holds valid data, registered.
REQ-013 pend1  out  1  addressed register was pending at the read, registered.
REQ-014 ren2, raddr2, bl2, vld2, pend2 SHALL match REQ-009..013 for port 2.
REQ-015 rsv  in  1  reserve request: mark one register pending.
REQ-016 rsv_addr  in  AW  register to reserve.
REQ-017 rsv_ok  out  1  reserve accepted, registered, 1-cycle latency.

Function
REQ-018 Storage SHALL be DEPTH x WIDTH flops plus a DEPTH-bit pending vector pend[].
REQ-019 Write: at an edge with rst=1, wen=1 and waddr<DEPTH, mem[waddr] SHALL take d and pend[waddr] SHALL clear.
REQ-020 A write with waddr>=DEPTH SHALL be ignored, with no state change.
REQ-021 Read latency SHALL be 1 cycle: after an edge with renN=1, blN=mem[raddrN], vldN=1 and pendN=pend[raddrN], with values sampled before that edge's update.
REQ-022 After an edge with renN=0, blN, vldN and pendN SHALL be 0 (outputs never float).
REQ-023 A read with raddrN>=DEPTH SHALL return blN=0, vldN=1, pendN=0.
REQ-024 Both ports SHALL read any address, including the same one, independently in the same cycle.
REQ-025 Reserve: at an edge with rsv=1 and rsv_addr<DEPTH, if pend[rsv_addr]=0 then pend SHALL be set and rsv_ok=1 next cycle; otherwise pend is unchanged and rsv_ok=0.
REQ-026 When wen and rsv hit the same address at the same edge, the write SHALL apply first and the reserve is then evaluated: pend ends set and rsv_ok=1.
REQ-027 rsv=0 or rsv_addr>=DEPTH SHALL give rsv_ok=0 the next cycle.
REQ-028 Writes, reserves and both reads SHALL complete in one cycle, with no stall or backpressure.

Reset
REQ-029 At an edge with rst=0, every mem word and pend bit SHALL clear, and bl1/bl2=0, vld1/vld2=0, pend1/pend2=0, rsv_ok=0.
REQ-030 Reset SHALL override wen, rsv, ren1 and ren2 at the same edge.
REQ-031 Reset asserted mid-operation SHALL discard in-flight reads, with no valid data the cycle after reset.

Configuration
REQ-032 Macro REGFILE_BYPASS_EN SHALL select write-to-read forwarding.
REQ-033 With REGFILE_BYPASS_EN defined, a read whose raddrN==waddr, with wen=1 at the same edge, SHALL return d and pendN=0.
REQ-034 With REGFILE_BYPASS_EN undefined, that read SHALL return the old mem value and the old pend bit.

Verification
REQ-035 rst=0 for 1 edge, then ren1=ren2=1 at addr 3 -> bl1=bl2=0x0000, vld=1, pend=0.
REQ-036 Write 0xBEEF to addr 5; next cycle ren1, raddr1=5 -> bl1=0xBEEF one cycle later; ren2=0 -> bl2=0, vld2=0.
REQ-037 Same edge: wen addr 2 data 0x1234, ren1 addr 2 (mem[2]=0) -> bl1=0x1234 with REGFILE_BYPASS_EN, 0x0000 without.
REQ-038 rsv addr 4 -> rsv_ok=1, read 4 gives pend=1; rsv addr 4 again -> rsv_ok=0; write addr 4 with rsv addr 4 at the same edge -> rsv_ok=1, pend[4]=1.
REQ-039 DEPTH=6: write 0xAAAA to addr 7 -> no register changes; read addr 7 -> bl=0, vld=1.
REQ-040 rst=0 with wen=1 and ren1=1 at the same edge -> all outputs 0 next cycle; mem[waddr] stays 0.
